load_store_unit: RTL and testbench

- Sits between the RV32 core's execute stage and the byte-lane data Memory block.
- Accepts one load/store request at a time.
- Converts the request into a word-aligned Memory access: word address, 4-bit byte write enables and lane-replicated write data.
- Returns load data extracted from the addressed lanes and sign- or zero-extended, or returns a fault for misaligned, out-of-range or illegal requests.

---
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32 load/store unit: turns one execute-stage request at a time into a word-aligned,
// byte-lane Memory access and returns extended load data or a fault.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned MEM_SIZE   = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [3:0]            mem_write_en,
    output logic [31:0]           mem_data_in,
    input  logic [31:0]           mem_data_out
);

    typedef enum logic [1:0] {StIdle, StAccess, StCapture, StResp} state_e;

    localparam logic [32:0] MemLimit = 33'(MEM_SIZE);

    state_e                  state_q, state_d;
    logic                    write_q, write_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [1:0]              off_q, off_d;
    logic                    req_ready_q, req_ready_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_fault_q, resp_fault_d;
    logic [31:0]             resp_rdata_q, resp_rdata_d;
    logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
    logic [3:0]              mem_write_en_q, mem_write_en_d;
    logic [31:0]             mem_data_in_q, mem_data_in_d;

    logic                    req_fault;
    logic [3:0]              lane_we;
    logic [31:0]             lane_data;
    logic [31:0]             shifted;
    logic [31:0]             load_result;

    // Request decode: fault detection and store lane mapping.
    always_comb begin
        logic misaligned, out_of_range, illegal;
        misaligned   = (((req_funct3 == 3'd1) || (req_funct3 == 3'd5)) && req_addr[0]) ||
                       ((req_funct3 == 3'd2) && (req_addr[1:0] != 2'b00));
        out_of_range = {1'b0, req_addr} >= MemLimit;
        illegal      = req_write ? (req_funct3 > 3'd2)
                                 : ((req_funct3 == 3'd3) || (req_funct3 == 3'd6) ||
                                    (req_funct3 == 3'd7));
        req_fault    = misaligned || out_of_range || illegal;

        lane_we   = 4'b1111;
        lane_data = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                lane_we   = 4'b0001 << req_addr[1:0];
                lane_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                lane_we   = req_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{req_wdata[15:0]}};
            end
            default: begin
                lane_we   = 4'b1111;
                lane_data = req_wdata;
            end
        endcase
    end

    // Bring the addressed lane(s) down to bit 0, then extend by width code.
    always_comb begin
        shifted = mem_data_out >> {off_q, 3'b000};
        case (funct3_q)
            3'd0:    load_result = {{24{shifted[7]}}, shifted[7:0]};
            3'd4:    load_result = {24'h0, shifted[7:0]};
            3'd1:    load_result = {{16{shifted[15]}}, shifted[15:0]};
            3'd5:    load_result = {16'h0, shifted[15:0]};
            default: load_result = shifted;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= StIdle;
            write_q        <= 1'b0;
            funct3_q       <= 3'd0;
            off_q          <= 2'd0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_fault_q   <= 1'b0;
            resp_rdata_q   <= 32'h0;
            mem_address_q  <= '0;
            mem_write_en_q <= 4'b0;
            mem_data_in_q  <= 32'h0;
        end else begin
            state_q        <= state_d;
            write_q        <= write_d;
            funct3_q       <= funct3_d;
            off_q          <= off_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_fault_q   <= resp_fault_d;
            resp_rdata_q   <= resp_rdata_d;
            mem_address_q  <= mem_address_d;
            mem_write_en_q <= mem_write_en_d;
            mem_data_in_q  <= mem_data_in_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (req_valid) state_d = req_fault ? StResp : StAccess;
            StAccess:  state_d = write_q ? StResp : StCapture;
            StCapture: state_d = StResp;
            StResp:    if (resp_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Registered outputs are computed one edge ahead so they line up with the next state.
    always_comb begin
        write_d        = write_q;
        funct3_d       = funct3_q;
        off_d          = off_q;
        req_ready_d    = req_ready_q;
        resp_valid_d   = resp_valid_q;
        resp_fault_d   = resp_fault_q;
        resp_rdata_d   = resp_rdata_q;
        mem_address_d  = mem_address_q;
        mem_write_en_d = 4'b0;
        mem_data_in_d  = mem_data_in_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d      = req_write;
                    funct3_d     = req_funct3;
                    off_d        = req_addr[1:0];
                    req_ready_d  = 1'b0;
                    resp_rdata_d = 32'h0;
                    resp_fault_d = req_fault;
                    if (req_fault) begin
                        resp_valid_d = 1'b1;
                    end else begin
                        mem_address_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (req_write) begin
                            mem_write_en_d = lane_we;
                            mem_data_in_d  = lane_data;
                        end
                    end
                end
            end
            StAccess: begin
                if (write_q) resp_valid_d = 1'b1;
            end
            StCapture: begin
                resp_rdata_d = load_result;
                resp_valid_d = 1'b1;
            end
            StResp: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_fault   = resp_fault_q;
    assign resp_rdata   = resp_rdata_q;
    assign mem_address  = mem_address_q;
    assign mem_write_en = mem_write_en_q;
    assign mem_data_in  = mem_data_in_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array Memory environment plus a request-level reference
// model; directed steps followed by randomized requests.
module tb_load_store_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [9:0]  mem_address;
    logic [3:0]  mem_write_en;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    int n_cmp;
    int n_err;
    logic mem_init;

    logic [7:0] env_mem [0:1023];
    logic [7:0] ref_mem [0:1023];

    load_store_unit #(
        .ADDR_WIDTH(10),
        .MEM_SIZE  (1024)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_fault  (resp_fault),
        .mem_address (mem_address),
        .mem_write_en(mem_write_en),
        .mem_data_in (mem_data_in),
        .mem_data_out(mem_data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory environment: byte-lane writes, one-cycle registered read.
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) env_mem[i] <= 8'(i * 37 + 11);
        end else begin
            for (int n = 0; n < 4; n++)
                if (mem_write_en[n]) env_mem[int'(mem_address) + n] <= mem_data_in[8*n +: 8];
        end
        mem_data_out <= {env_mem[int'(mem_address) + 3], env_mem[int'(mem_address) + 2],
                         env_mem[int'(mem_address) + 1], env_mem[int'(mem_address)]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Request-level reference: access size, alignment, range and legality rules,
    // little-endian byte assembly and extension.
    task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic fault,
                         output logic [31:0] rdata, output logic [3:0] mask);
        int size;
        logic [31:0] val;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        fault = (addr >= 32'd1024) || (w ? (f3 > 3'd2) : (f3 == 3 || f3 == 6 || f3 == 7)) ||
                ((addr % size) != 0);
        rdata = 32'h0;
        mask  = 4'h0;
        if (!fault && w) begin
            for (int i = 0; i < size; i++) begin
                ref_mem[addr + i] = wdata[8*i +: 8];
                mask[(addr % 4) + i] = 1'b1;
            end
        end else if (!fault) begin
            val = 32'h0;
            for (int i = 0; i < size; i++) val = val | (32'(ref_mem[addr + i]) << (8 * i));
            if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8 * size));
            rdata = val;
        end
    endtask

    task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int stall);
        logic        e_fault;
        logic [31:0] e_rdata;
        logic [3:0]  e_mask;
        int          e_lat, cycles, n_we, off;
        model(w, f3, addr, wdata, e_fault, e_rdata, e_mask);
        e_lat = e_fault ? 1 : (w ? 2 : 3);
        off   = int'(addr % 4);
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        cycles    = 1;
        n_we      = 0;
        if (!e_fault) check("mem_address", 32'(mem_address), addr & 32'h3FC);
        while (resp_valid !== 1'b1 && cycles < 8) begin
            if (mem_write_en !== 4'b0) begin
                n_we++;
                check("write_en", 32'(mem_write_en), 32'(e_mask));
                for (int n = 0; n < 4; n++)
                    if (e_mask[n])
                        check("data_in_lane", 32'(mem_data_in[8*n +: 8]),
                              32'(wdata[8*(n - off) +: 8]));
            end
            @(negedge clock);
            cycles++;
        end
        check("latency", 32'(cycles), 32'(e_lat));
        check("fault", 32'(resp_fault), 32'(e_fault));
        check("rdata", resp_rdata, e_rdata);
        check("write_count", 32'(n_we), (w && !e_fault) ? 32'd1 : 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_rdata", resp_rdata, e_rdata);
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_we", 32'(mem_write_en), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        check("resp_drop", 32'(resp_valid), 32'd0);
        check("ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b0;
        mem_init   = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 37 + 11);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset    = 1'b1;
        mem_init = 1'b0;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_fault", 32'(resp_fault), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_we", 32'(mem_write_en), 32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        check("rst_din", mem_data_in, 32'h0);

        run_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        run_req(1'b0, 3'd2, 32'h10, 32'h0, 0);
        run_req(1'b1, 3'd0, 32'h21, 32'h80, 0);
        run_req(1'b0, 3'd0, 32'h21, 32'h0, 0);
        run_req(1'b0, 3'd4, 32'h21, 32'h0, 0);
        run_req(1'b1, 3'd1, 32'h32, 32'h1234A5A5, 0);
        run_req(1'b0, 3'd1, 32'h32, 32'h0, 0);
        run_req(1'b0, 3'd5, 32'h32, 32'h0, 0);
        run_req(1'b0, 3'd2, 32'h13, 32'h0, 0);
        run_req(1'b1, 3'd1, 32'h05, 32'hFFFF, 0);
        run_req(1'b0, 3'd2, 32'h400, 32'h0, 0);
        run_req(1'b0, 3'd3, 32'h20, 32'h0, 0);
        run_req(1'b1, 3'd4, 32'h20, 32'h0, 0);
        run_req(1'b0, 3'd2, 32'h3FC, 32'h0, 0);
        run_req(1'b0, 3'd2, 32'h10, 32'h0, 5);

        // Abort a load in CAPTURE with reset.
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h10;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("abort_valid", 32'(resp_valid), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_we", 32'(mem_write_en), 32'd0);
        @(negedge clock);
        check("abort_valid2", 32'(resp_valid), 32'd0);
        run_req(1'b0, 3'd2, 32'h10, 32'h0, 0);

        for (int k = 0; k < 60; k++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a = $urandom();
            else a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1 && !w) f3 = 3'($urandom_range(0, 2));
            run_req(w, f3, a, $urandom(), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
